// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-entry holding
// register with valid/ready handshake, frame-error pulse and sticky overrun flag.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_ready,
    input  logic       overrun_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    localparam logic [15:0] HALF_TICK = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_TICK = 16'(CLKS_PER_BIT - 1);

    logic        rx_meta_q, rx_s_q;
    logic [1:0]  sync_cnt_q, sync_cnt_d;
    logic        armed_q, armed_d;
    logic [2:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic        good_frame;
    logic        load;

    // Starts are ignored until the synchronizer holds a real sample of a high line, so a
    // reset released mid-frame cannot lock onto a data bit.
    always_comb begin
        sync_cnt_d = (sync_cnt_q == 2'd2) ? sync_cnt_q : sync_cnt_q + 2'd1;
        armed_d    = armed_q | ((sync_cnt_q == 2'd2) & rx_s_q);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        good_frame  = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (armed_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (timer_q == HALF_TICK) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DATA: begin
                if (timer_q == FULL_TICK) begin
                    timer_d         = '0;
                    shift_d[idx_q]  = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            STOP: begin
                if (timer_q == FULL_TICK) begin
                    timer_d = '0;
                    if (rx_s_q) begin
                        good_frame = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // A byte loads when the holding register is empty or being drained this same cycle.
    always_comb begin
        load      = good_frame & (~valid_q | rx_ready);
        data_d    = load ? shift_q : data_q;
        valid_d   = load ? 1'b1 : ((valid_q & rx_ready) ? 1'b0 : valid_q);
        overrun_d = (good_frame & valid_q & ~rx_ready) ? 1'b1 :
                    (overrun_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            sync_cnt_q  <= 2'd0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            timer_q     <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            sync_cnt_q  <= sync_cnt_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; expected values are hand-computed.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       rx_ready;
    logic       overrun_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks;
    int n_errors;
    int fe_cnt;
    int busy_seen;
    int cnt;
    logic [7:0] got_q[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_ready   (rx_ready),
        .overrun_clr(overrun_clr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (busy) busy_seen = 1;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        fe_cnt      = 0;
        busy_seen   = 0;
        rx          = 1'b1;
        rx_ready    = 1'b0;
        overrun_clr = 1'b0;
        rst_n       = 1'b0;

        @(negedge clk);
        check_eq("rst_valid", rx_valid, 0);
        check_eq("rst_data", rx_data, 8'h00);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_ovr", overrun, 0);
        check_eq("rst_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        tick(10);

        // Single byte held, then drained
        fe_cnt = 0;
        send_byte(8'hA5, 1'b1);
        tick(4);
        @(negedge clk);
        check_eq("a5_valid", rx_valid, 1);
        check_eq("a5_data", rx_data, 8'hA5);
        check_eq("a5_ferr", fe_cnt, 0);
        check_eq("a5_ovr", overrun, 0);
        tick(0);
        @(posedge clk);
        #1;
        consume();
        @(negedge clk);
        check_eq("a5_drain", rx_valid, 0);
        tick(5);

        // Short glitch is rejected
        fe_cnt = 0;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        cnt = 0;
        while (!busy && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("gl_started", busy, 1);
        cnt = 0;
        while (busy && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("gl_idle_in_8", (cnt <= 8 && !busy), 1);
        check_eq("gl_valid", rx_valid, 0);
        check_eq("gl_ferr", fe_cnt, 0);
        tick(5);

        // Framing error followed by a held-low line
        fe_cnt = 0;
        send_byte(8'h3C, 1'b0);
        tick(40);
        @(negedge clk);
        check_eq("fe_count", fe_cnt, 1);
        check_eq("fe_valid", rx_valid, 0);
        check_eq("fe_busy_wait", busy, 1);
        #1;
        rx = 1'b1;
        tick(5);
        @(negedge clk);
        check_eq("fe_idle", busy, 0);
        #1;
        tick(5);
        send_byte(8'h55, 1'b1);
        tick(4);
        @(negedge clk);
        check_eq("fe_55_valid", rx_valid, 1);
        check_eq("fe_55_data", rx_data, 8'h55);
        check_eq("fe_count_after", fe_cnt, 1);
        #1;
        consume();
        tick(5);

        // Overrun
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(4);
        @(negedge clk);
        check_eq("ov_data", rx_data, 8'h11);
        check_eq("ov_flag", overrun, 1);
        check_eq("ov_valid", rx_valid, 1);
        #1;
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        @(negedge clk);
        check_eq("ov_clr", overrun, 0);
        check_eq("ov_data_kept", rx_data, 8'h11);
        #1;
        consume();
        tick(5);

        // Back-to-back with consumer always ready
        got_q.delete();
        rx_ready = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h81, 1'b1);
        tick(10);
        rx_ready = 1'b0;
        check_eq("b2b_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check_eq("b2b_0", got_q[0], 8'h00);
            check_eq("b2b_1", got_q[1], 8'hFF);
            check_eq("b2b_2", got_q[2], 8'h81);
        end
        @(negedge clk);
        check_eq("b2b_valid", rx_valid, 0);
        check_eq("b2b_ovr", overrun, 0);
        #1;
        tick(5);

        // Reset during bit 4 of 8'hC3, released while the line is still low
        fe_cnt = 0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
        rx = 1'b0;
        tick(6);
        rst_n = 1'b0;
        #1;
        check_eq("mr_valid", rx_valid, 0);
        check_eq("mr_data", rx_data, 8'h00);
        check_eq("mr_busy", busy, 0);
        check_eq("mr_ovr", overrun, 0);
        tick(3);
        busy_seen = 0;
        rst_n = 1'b1;
        tick(CPB - 9);
        for (int i = 5; i < 8; i++) send_bit(1'(8'hC3 >> i));
        send_bit(1'b1);
        tick(20);
        check_eq("mr_no_start", busy_seen, 0);
        check_eq("mr_no_byte", rx_valid, 0);
        check_eq("mr_no_ferr", fe_cnt, 0);
        send_byte(8'h7E, 1'b1);
        tick(4);
        @(negedge clk);
        check_eq("mr_7e_valid", rx_valid, 1);
        check_eq("mr_7e_data", rx_data, 8'h7E);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
